// File: rtl/tlp_stream_reader.sv
// tlp_stream_reader: frames FIFO headers and payload into valid/ready TLPs and checks header sequence numbers
module tlp_stream_reader #(
  parameter int WORDS_PER_TLP = 15,
  parameter int SEQ_CNT_W = 16
) (
  input  logic                 InputClock,
  input  logic                 rst,
  input  logic [39:0]          HeaderData,
  input  logic                 HeaderEmpty,
  output logic                 HeaderReadEnable,
  input  logic [63:0]          DataFifoData,
  input  logic                 DataEmpty,
  output logic                 DataReadEnable,
  input  logic [15:0]          BufferLengthTLPs,
  output logic [63:0]          TxData,
  output logic                 TxValid,
  input  logic                 TxReady,
  output logic                 TxSop,
  output logic                 TxEop,
  output logic [39:0]          TxHeader,
  output logic [SEQ_CNT_W-1:0] SeqErrorCount,
  output logic [SEQ_CNT_W-1:0] PacketCount,
  output logic                 UnderflowFlag
);
  typedef enum logic {IDLE, DATA} state_t;
  state_t state_q, state_d;
  logic [3:0] beat_q, beat_d;
  logic [39:0] hdr_q, hdr_d;
  logic armed_q, armed_d;
  logic [15:0] exp_b_q, exp_b_d;
  logic [16:0] exp_t_q, exp_t_d;
  logic [SEQ_CNT_W-1:0] err_q, err_d, pkt_q, pkt_d;
  logic uflow_q, uflow_d;
  logic in_data, tx_valid, accept, at_last, last, pop, bad, wrap;
  logic [15:0] b, t;
  always_comb begin
    b = HeaderData[39:24];
    t = HeaderData[23:8];
    in_data = state_q == DATA;
    tx_valid = in_data & ~DataEmpty;
    accept = tx_valid & TxReady;
    at_last = beat_q == 4'(WORDS_PER_TLP - 1);
    last = accept & at_last;
    pop = ~HeaderEmpty & (~in_data | last);
    bad = armed_q & ((b != exp_b_q) | ({1'b0, t} != exp_t_q) | (HeaderData[4:0] != 5'h1f));
    wrap = t >= BufferLengthTLPs;
    state_d = pop ? DATA : last ? IDLE : state_q;
    beat_d = pop ? 4'd0 : accept ? beat_q + 4'd1 : beat_q;
    hdr_d = pop ? HeaderData : hdr_q;
    armed_d = armed_q | pop;
    exp_b_d = pop ? (wrap ? b + 16'd1 : b) : exp_b_q;
    exp_t_d = pop ? (wrap ? 17'd0 : {1'b0, t} + 17'd1) : exp_t_q;
    err_d = (pop & bad & ~(&err_q)) ? err_q + SEQ_CNT_W'(1) : err_q;
    pkt_d = last ? pkt_q + SEQ_CNT_W'(1) : pkt_q;
    uflow_d = uflow_q | (in_data & DataEmpty);
  end
  always_ff @(posedge InputClock) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= '0;
      hdr_q <= '0;
      armed_q <= 1'b0;
      exp_b_q <= '0;
      exp_t_q <= '0;
      err_q <= '0;
      pkt_q <= '0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      hdr_q <= hdr_d;
      armed_q <= armed_d;
      exp_b_q <= exp_b_d;
      exp_t_q <= exp_t_d;
      err_q <= err_d;
      pkt_q <= pkt_d;
      uflow_q <= uflow_d;
    end
  end
  assign HeaderReadEnable = pop;
  assign DataReadEnable = accept;
  assign TxValid = tx_valid;
  assign TxData = tx_valid ? DataFifoData : '0;
  assign TxSop = tx_valid & (beat_q == 4'd0);
  assign TxEop = tx_valid & at_last;
  assign TxHeader = hdr_q;
  assign SeqErrorCount = err_q;
  assign PacketCount = pkt_q;
  assign UnderflowFlag = uflow_q;
endmodule

// File: tb/tb_tlp_stream_reader.sv
// tb_tlp_stream_reader: directed bench with FWFT FIFO models feeding tlp_stream_reader
module tb_tlp_stream_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [39:0] HeaderData;
  logic HeaderEmpty, HeaderReadEnable;
  logic [63:0] DataFifoData;
  logic DataEmpty, DataReadEnable;
  logic [15:0] BufferLengthTLPs;
  logic [63:0] TxData;
  logic TxValid, TxReady, TxSop, TxEop;
  logic [39:0] TxHeader;
  logic [15:0] SeqErrorCount, PacketCount;
  logic UnderflowFlag;
  tlp_stream_reader dut (
    .InputClock(clk),
    .rst(rst),
    .HeaderData(HeaderData),
    .HeaderEmpty(HeaderEmpty),
    .HeaderReadEnable(HeaderReadEnable),
    .DataFifoData(DataFifoData),
    .DataEmpty(DataEmpty),
    .DataReadEnable(DataReadEnable),
    .BufferLengthTLPs(BufferLengthTLPs),
    .TxData(TxData),
    .TxValid(TxValid),
    .TxReady(TxReady),
    .TxSop(TxSop),
    .TxEop(TxEop),
    .TxHeader(TxHeader),
    .SeqErrorCount(SeqErrorCount),
    .PacketCount(PacketCount),
    .UnderflowFlag(UnderflowFlag)
  );
  logic [39:0] hq[$];
  logic [63:0] dq[$];
  logic [63:0] rx[$];
  int checks = 0, failures = 0;
  int sops, eops, eop_idx, pops, unstable, stalls;
  logic hre, dre, pv, pr, ps, pe;
  logic [63:0] pd;
  logic [3:0] pat = 4'b1001;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [39:0] hdr(input logic [15:0] b, input logic [15:0] t, input logic [4:0] f);
    return {b, t, 3'b101, f};
  endfunction
  task automatic refresh();
    HeaderEmpty = hq.size() == 0;
    HeaderData = HeaderEmpty ? 40'd0 : hq[0];
    DataEmpty = dq.size() == 0;
    DataFifoData = DataEmpty ? 64'd0 : dq[0];
  endtask
  task automatic step();
    hre = HeaderReadEnable;
    dre = DataReadEnable;
    if (TxValid && TxReady) begin
      rx.push_back(TxData);
      if (TxSop) sops++;
      if (TxEop) begin
        eops++;
        eop_idx = rx.size();
      end
    end
    @(posedge clk);
    #1;
    if (hre && hq.size() > 0) void'(hq.pop_front());
    if (dre && dq.size() > 0) void'(dq.pop_front());
    if (dre) pops++;
    if (rst) begin
      hq.delete();
      dq.delete();
    end
    refresh();
    #1;
  endtask
  task automatic clr_log();
    rx.delete();
    sops = 0;
    eops = 0;
    eop_idx = 0;
    pops = 0;
  endtask
  task automatic push_data(input int base, input int n);
    for (int i = 0; i < n; i++) dq.push_back(64'(base + i + 1));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clr_log();
  endtask
  task automatic check_rx(input string tag, input int n, input int base);
    int bad = 0;
    check({tag, "_len"}, 64'(rx.size()), 64'(n));
    for (int i = 0; i < rx.size(); i++) if (rx[i] !== 64'(base + i + 1)) bad++;
    check({tag, "_data"}, 64'(bad), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    TxReady = 1'b1;
    BufferLengthTLPs = 16'd100;
    refresh();
    #2;
    do_reset();
    check("rst_valid", TxValid, 0);
    check("rst_hre", HeaderReadEnable, 0);
    check("rst_dre", DataReadEnable, 0);
    check("rst_header", TxHeader, 0);
    check("rst_counts", {SeqErrorCount, PacketCount}, 0);
    check("rst_uflow", UnderflowFlag, 0);
    push_data(0, 15);
    hq.push_back(hdr(16'd0, 16'd0, 5'h1f));
    refresh();
    #1;
    check("t1_hre", HeaderReadEnable, 1);
    check("t1_idle_valid", TxValid, 0);
    step();
    check("t1_header", TxHeader, hdr(16'd0, 16'd0, 5'h1f));
    check("t1_first", {TxValid, TxSop, TxEop}, 3'b110);
    check("t1_data1", TxData, 1);
    repeat (14) step();
    check("t1_last", {TxValid, TxSop, TxEop}, 3'b101);
    check("t1_data15", TxData, 15);
    step();
    check("t1_done_valid", TxValid, 0);
    check("t1_pkt", PacketCount, 1);
    check("t1_seq", SeqErrorCount, 0);
    check_rx("t1_rx", 15, 0);
    do_reset();
    BufferLengthTLPs = 16'd2;
    hq.push_back(hdr(16'd5, 16'd0, 5'h1f));
    hq.push_back(hdr(16'd5, 16'd1, 5'h1f));
    hq.push_back(hdr(16'd5, 16'd2, 5'h1f));
    hq.push_back(hdr(16'd6, 16'd0, 5'h1f));
    push_data(100, 60);
    refresh();
    #1;
    repeat (61) step();
    check_rx("t2_rx", 60, 100);
    check("t2_seq", SeqErrorCount, 0);
    check("t2_pkt", PacketCount, 4);
    check("t2_sop_eop", {32'(sops), 32'(eops)}, {32'd4, 32'd4});
    do_reset();
    BufferLengthTLPs = 16'd100;
    hq.push_back(hdr(16'd0, 16'd0, 5'h1f));
    hq.push_back(hdr(16'd0, 16'd1, 5'h1f));
    hq.push_back(hdr(16'd0, 16'd3, 5'h1f));
    hq.push_back(hdr(16'd0, 16'd4, 5'h1f));
    push_data(400, 60);
    refresh();
    #1;
    repeat (61) step();
    check("t3_seq_gap", SeqErrorCount, 1);
    hq.push_back(hdr(16'd0, 16'd9, 5'h00));
    push_data(460, 15);
    refresh();
    #1;
    repeat (16) step();
    check("t3_seq_both", SeqErrorCount, 2);
    check("t3_pkt", PacketCount, 5);
    check_rx("t3_rx", 75, 400);
    do_reset();
    hq.push_back(hdr(16'd1, 16'd0, 5'h1f));
    push_data(200, 15);
    refresh();
    #1;
    unstable = 0;
    stalls = 0;
    pv = 1'b0;
    pr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      TxReady = pat[k % 4];
      #1;
      if (pv && !pr) begin
        stalls++;
        if (TxValid !== 1'b1 || TxData !== pd || TxSop !== ps || TxEop !== pe) unstable++;
      end
      pv = TxValid;
      pr = TxReady;
      pd = TxData;
      ps = TxSop;
      pe = TxEop;
      step();
    end
    TxReady = 1'b1;
    check("t4_pops", 64'(pops), 15);
    check("t4_stable", 64'(unstable), 0);
    check("t4_stalled", 64'(stalls > 0), 1);
    check_rx("t4_rx", 15, 200);
    check("t4_eops", 64'(eops), 1);
    check("t4_pkt", PacketCount, 1);
    do_reset();
    hq.push_back(hdr(16'd2, 16'd0, 5'h1f));
    push_data(300, 7);
    refresh();
    #1;
    repeat (8) step();
    for (int i = 0; i < 3; i++) begin
      check("t5_stall_valid", TxValid, 0);
      step();
    end
    push_data(307, 8);
    refresh();
    #1;
    check("t5_uflow", UnderflowFlag, 1);
    repeat (8) step();
    check_rx("t5_rx", 15, 300);
    check("t5_eop_idx", 64'(eop_idx), 15);
    check("t5_eops", 64'(eops), 1);
    check("t5_pkt", PacketCount, 1);
    check("t5_uflow_sticky", UnderflowFlag, 1);
    clr_log();
    hq.push_back(hdr(16'd3, 16'd0, 5'h1f));
    push_data(500, 15);
    refresh();
    #1;
    repeat (9) step();
    check("t6_pre_beats", 64'(rx.size()), 8);
    check("t6_pre_data", TxData, 509);
    check("t6_pre_seq", SeqErrorCount, 1);
    rst = 1'b1;
    step();
    check("t6_rst_tx", {TxValid, TxSop, TxEop, DataReadEnable, HeaderReadEnable}, 0);
    check("t6_rst_data", TxData, 0);
    check("t6_rst_header", TxHeader, 0);
    check("t6_rst_counts", {SeqErrorCount, PacketCount}, 0);
    check("t6_rst_uflow", UnderflowFlag, 0);
    check("t6_no_eop", 64'(eops), 0);
    rst = 1'b0;
    clr_log();
    hq.push_back(hdr(16'd7, 16'd3, 5'h1f));
    push_data(600, 15);
    refresh();
    #1;
    repeat (16) step();
    check("t6_seq_unarmed", SeqErrorCount, 0);
    check("t6_pkt", PacketCount, 1);
    check_rx("t6_rx", 15, 600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
